// File: rtl/ps2_kbd_ctrl.sv
// ps2_kbd_ctrl -- PS/2 keyboard receive controller.
// The raw PS/2 clock and data pins are oversampled in the clk domain. The
// block assembles 11-bit frames and checks start, stop and odd parity. A
// sequencer folds E0/F0 prefix bytes into single key events. Events are
// buffered in a show-ahead FIFO and offered over a valid/ready handshake.
// Optional feature: define PS2_KBD_TIMEOUT_EN to abandon partial frames
// after TIMEOUT_CYCLES clk cycles with no PS/2 falling edge.
module ps2_kbd_ctrl #(
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       evt_valid,
  input  logic       evt_ready,
  output logic [7:0] evt_code,
  output logic       evt_break,
  output logic       evt_ext,
  output logic       overflow,
  input  logic       clr_overflow,
  output logic [7:0] err_count
);

  localparam int AW = $clog2(FIFO_DEPTH);

  // Reject nonsensical configurations at elaboration time.
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("ps2_kbd_ctrl: FIFO_DEPTH must be a power of two >= 2 and TIMEOUT_CYCLES >= 1");
  end

  // Saturating increment for the rejected-frame counter.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Frame check: f holds bits 0..9 (start, data[7:0], parity); stop is bit 10.
  // The XOR of the data bits and the parity bit must be 1 (odd parity).
  function automatic logic frame_ok(input logic [9:0] f, input logic stop);
    return (f[0] == 1'b0) && stop && (^f[9:1]);
  endfunction

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_EXT     = 2'd1,
    S_BRK     = 2'd2,
    S_EXT_BRK = 2'd3
  } state_t;

  logic [2:0]    clk_sync;
  logic [1:0]    data_sync;
  logic          strobe_p0;
  logic          bit_p0;
  logic [3:0]    bit_cnt;
  logic [9:0]    frame_p0;
  logic          byte_vld_p1;
  logic [7:0]    byte_p1;
  state_t        state;
  state_t        state_nxt;
  logic          push;
  logic          push_brk;
  logic          push_ext;
  logic          push_ok;
  logic          pop;
  logic          full;
  logic          empty;
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic [9:0]    mem [FIFO_DEPTH];
  logic [9:0]    head;

`ifdef PS2_KBD_TIMEOUT_EN
  localparam int IW = $clog2(TIMEOUT_CYCLES + 1);
  logic [IW-1:0] idle_cnt;
`endif

  // ---- stage p0: pin synchronisers and falling-edge strobe ----

  // Shift the asynchronous pins into the clk domain; both idle high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_sync  <= 3'b111;
      data_sync <= 2'b11;
    end else begin
      clk_sync  <= {clk_sync[1:0], ps2_clk};
      data_sync <= {data_sync[0], ps2_data};
    end
  end

  // Older sample high and newer sample low marks exactly one PS/2 falling edge.
  assign strobe_p0 = clk_sync[2] & ~clk_sync[1];
  assign bit_p0    = data_sync[1];

  // Capture frame bits 0..9 LSB first; the stop bit is checked live.
  always_ff @(posedge clk) begin
    if (strobe_p0 && bit_cnt != 4'd10) begin
      frame_p0[bit_cnt] <= bit_p0;
    end
  end

  // ---- stage p1: frame validation and byte strobe ----

  // Latch the data byte on the stop-bit strobe; qualified by byte_vld_p1.
  always_ff @(posedge clk) begin
    if (strobe_p0 && bit_cnt == 4'd10) begin
      byte_p1 <= frame_p0[8:1];
    end
  end

  // Bit counter, byte strobe, error counter and optional idle timeout.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bit_cnt     <= '0;
      byte_vld_p1 <= 1'b0;
      err_count   <= '0;
`ifdef PS2_KBD_TIMEOUT_EN
      idle_cnt    <= '0;
`endif
    end else begin
      byte_vld_p1 <= 1'b0;
      if (strobe_p0) begin
`ifdef PS2_KBD_TIMEOUT_EN
        idle_cnt <= '0;
`endif
        if (bit_cnt == 4'd10) begin
          bit_cnt <= '0;
          if (frame_ok(frame_p0, bit_p0)) begin
            byte_vld_p1 <= 1'b1;
          end else begin
            err_count <= sat_inc8(err_count);
          end
        end else begin
          bit_cnt <= bit_cnt + 4'd1;
        end
      end
`ifdef PS2_KBD_TIMEOUT_EN
      else if (bit_cnt != 4'd0) begin
        // A stalled partial frame is dropped so the next start bit resyncs.
        if (idle_cnt == IW'(TIMEOUT_CYCLES - 1)) begin
          bit_cnt   <= '0;
          idle_cnt  <= '0;
          err_count <= sat_inc8(err_count);
        end else begin
          idle_cnt <= idle_cnt + IW'(1);
        end
      end else begin
        idle_cnt <= '0;
      end
`endif
    end
  end

  // ---- stage p2: prefix sequencer and event FIFO ----

  // Sequencer state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Fold E0 (extended) and F0 (break) prefixes into the event that follows.
  always_comb begin
    state_nxt = state;
    push      = 1'b0;
    push_brk  = 1'b0;
    push_ext  = 1'b0;
    if (byte_vld_p1) begin
      unique case (state)
        S_IDLE: begin
          if (byte_p1 == 8'hE0) begin
            state_nxt = S_EXT;
          end else if (byte_p1 == 8'hF0) begin
            state_nxt = S_BRK;
          end else begin
            push = 1'b1;
          end
        end
        S_EXT: begin
          if (byte_p1 == 8'hF0) begin
            state_nxt = S_EXT_BRK;
          end else if (byte_p1 == 8'hE0) begin
            state_nxt = S_EXT;
          end else begin
            push      = 1'b1;
            push_ext  = 1'b1;
            state_nxt = S_IDLE;
          end
        end
        S_BRK: begin
          if (byte_p1 == 8'hF0) begin
            state_nxt = S_BRK;
          end else if (byte_p1 == 8'hE0) begin
            state_nxt = S_EXT_BRK;
          end else begin
            push      = 1'b1;
            push_brk  = 1'b1;
            state_nxt = S_IDLE;
          end
        end
        S_EXT_BRK: begin
          if (byte_p1 == 8'hE0 || byte_p1 == 8'hF0) begin
            state_nxt = S_EXT_BRK;
          end else begin
            push      = 1'b1;
            push_brk  = 1'b1;
            push_ext  = 1'b1;
            state_nxt = S_IDLE;
          end
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // The extra pointer MSB separates full (MSBs differ) from empty (equal).
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop     = evt_valid & evt_ready;
  // A pop in the same cycle frees the slot the push is about to fill.
  assign push_ok = push & (~full | pop);

  // FIFO storage; entries are {break, ext, code}.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr[AW-1:0]] <= {push_brk, push_ext, byte_p1};
    end
  end

  // FIFO pointers and the sticky overflow flag (set wins over clear).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push && !push_ok) begin
        overflow <= 1'b1;
      end else if (clr_overflow) begin
        overflow <= 1'b0;
      end
    end
  end

  // Show-ahead head: fields are meaningful only while evt_valid is high.
  assign head      = mem[rd_ptr[AW-1:0]];
  assign evt_valid = ~empty;
  assign evt_code  = head[7:0];
  assign evt_ext   = head[8];
  assign evt_break = head[9];

endmodule

// File: tb/tb_ps2_kbd_ctrl.sv
// tb_ps2_kbd_ctrl -- self-checking bench for ps2_kbd_ctrl.
// A PS/2 device model drives frames; expected events go into a scoreboard
// queue and are compared by a monitor whenever the DUT hands one over.
// Build with PS2_KBD_TIMEOUT_EN defined to include the idle-timeout sequence.
module tb_ps2_kbd_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       ps2_clk;
  logic       ps2_data;
  logic       evt_valid;
  logic       evt_ready;
  logic [7:0] evt_code;
  logic       evt_break;
  logic       evt_ext;
  logic       overflow;
  logic       clr_overflow;
  logic [7:0] err_count;

  int         total = 0;
  int         bad = 0;
  int         vld_cycles = 0;
  int         exp_err = 0;
  logic [9:0] sb[$];
  logic [9:0] exp_head;

  typedef struct {
    logic [23:0] bytes;   // byte j at [j*8 +: 8], sent in order
    int          nb;
    logic        bad0;    // corrupt the parity of the first byte
    logic [9:0]  exp;     // {break, ext, code}
  } vec_t;

  vec_t vecs [8];

  always #5 clk = ~clk;

  ps2_kbd_ctrl #(
    .FIFO_DEPTH    (8),
    .TIMEOUT_CYCLES(100)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .ps2_clk     (ps2_clk),
    .ps2_data    (ps2_data),
    .evt_valid   (evt_valid),
    .evt_ready   (evt_ready),
    .evt_code    (evt_code),
    .evt_break   (evt_break),
    .evt_ext     (evt_ext),
    .overflow    (overflow),
    .clr_overflow(clr_overflow),
    .err_count   (err_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every handshake pops the scoreboard and compares the event.
  always @(negedge clk) begin
    if (!reset) begin
      if (evt_valid) vld_cycles++;
      if (evt_valid && evt_ready) begin
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL evt_unexpected: got %h expected none", {evt_break, evt_ext, evt_code});
        end else begin
          exp_head = sb.pop_front();
          if ({evt_break, evt_ext, evt_code} !== exp_head) begin
            bad++;
            $display("FAIL evt: got %h expected %h", {evt_break, evt_ext, evt_code}, exp_head);
          end
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drive the first n bits of a frame, LSB first, as a PS/2 device would.
  task automatic send_bits(input logic [10:0] f, input int n);
    for (int i = 0; i < n; i++) begin
      ps2_data = f[i];
      cyc(5);
      ps2_clk = 1'b0;
      cyc(8);
      ps2_clk = 1'b1;
      cyc(5);
    end
  endtask

  function automatic logic [10:0] mk_frame(input logic [7:0] b, input logic badp);
    return {1'b1, ~(^b) ^ badp, b, 1'b0};
  endfunction

  task automatic send_byte(input logic [7:0] b, input logic badp);
    send_bits(mk_frame(b, badp), 11);
    ps2_data = 1'b1;
    cyc(3);
  endtask

  task automatic drain(input string name);
    int k = 0;
    while (sb.size() != 0 && k < 300) begin
      cyc(1);
      k++;
    end
    cyc(3);
    chk(name, sb.size(), 0);
  endtask

  initial begin : watchdog
    #2ms;
    $display("FAIL watchdog: got timeout expected test end");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{bytes: 24'h00001C, nb: 1, bad0: 1'b0, exp: {2'b00, 8'h1C}};
    vecs[1] = '{bytes: 24'h75F0E0, nb: 3, bad0: 1'b0, exp: {2'b11, 8'h75}};
    vecs[2] = '{bytes: 24'h00321C, nb: 2, bad0: 1'b1, exp: {2'b00, 8'h32}};
    vecs[3] = '{bytes: 24'h001CF0, nb: 2, bad0: 1'b0, exp: {2'b10, 8'h1C}};
    vecs[4] = '{bytes: 24'h006BE0, nb: 2, bad0: 1'b0, exp: {2'b01, 8'h6B}};
    vecs[5] = '{bytes: 24'h74E0E0, nb: 3, bad0: 1'b0, exp: {2'b01, 8'h74}};
    vecs[6] = '{bytes: 24'h29F0F0, nb: 3, bad0: 1'b0, exp: {2'b10, 8'h29}};
    vecs[7] = '{bytes: 24'h11E0F0, nb: 3, bad0: 1'b0, exp: {2'b11, 8'h11}};

    reset = 1'b1;
    ps2_clk = 1'b1;
    ps2_data = 1'b1;
    evt_ready = 1'b1;
    clr_overflow = 1'b0;
    cyc(4);
    reset = 1'b0;
    cyc(2);
    chk("rst_valid", evt_valid, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_err", err_count, 0);

    // Single make code with ready high: valid lasts exactly one cycle.
    vld_cycles = 0;
    sb.push_back({2'b00, 8'h1C});
    send_byte(8'h1C, 1'b0);
    drain("single_drain");
    chk("single_vld_cycles", vld_cycles, 1);
    chk("single_err", err_count, 0);

    for (int i = 0; i < 8; i++) begin
      sb.push_back(vecs[i].exp);
      if (vecs[i].bad0) exp_err++;
      for (int j = 0; j < vecs[i].nb; j++) begin
        send_byte(vecs[i].bytes[j*8 +: 8], (j == 0) && vecs[i].bad0);
      end
      drain($sformatf("vec%0d_drain", i));
      chk($sformatf("vec%0d_err", i), err_count, exp_err);
    end

    // Nine makes into an eight-deep FIFO with the consumer stalled.
    evt_ready = 1'b0;
    for (int k = 0; k < 9; k++) begin
      if (k < 8) sb.push_back({2'b00, 8'h15 + 8'(k)});
      send_byte(8'h15 + 8'(k), 1'b0);
    end
    cyc(5);
    chk("ovf_valid", evt_valid, 1);
    chk("ovf_flag", overflow, 1);
    chk("ovf_head", evt_code, 8'h15);
    evt_ready = 1'b1;
    vld_cycles = 0;
    drain("ovf_drain");
    chk("ovf_burst_cycles", vld_cycles, 8);
    chk("ovf_valid_low", evt_valid, 0);
    chk("ovf_sticky", overflow, 1);
    clr_overflow = 1'b1;
    cyc(1);
    clr_overflow = 1'b0;
    chk("ovf_cleared", overflow, 0);

`ifdef PS2_KBD_TIMEOUT_EN
    // Partial frame abandoned by the idle timeout, then a clean frame.
    send_bits(mk_frame(8'h1C, 1'b0), 5);
    ps2_data = 1'b1;
    cyc(150);
    exp_err++;
    chk("tmo_err_mid", err_count, exp_err);
    sb.push_back({2'b00, 8'h1C});
    send_byte(8'h1C, 1'b0);
    drain("tmo_drain");
    chk("tmo_err", err_count, exp_err);
`endif

    // Reset mid-frame with a stale event held in the FIFO.
    evt_ready = 1'b0;
    send_byte(8'h2A, 1'b0);
    cyc(5);
    chk("stale_held", evt_valid, 1);
    send_bits(mk_frame(8'hF0, 1'b0), 7);
    #3;
    reset = 1'b1;
    cyc(2);
    chk("mid_rst_valid", evt_valid, 0);
    chk("mid_rst_err", err_count, 0);
    reset = 1'b0;
    ps2_data = 1'b1;
    evt_ready = 1'b1;
    exp_err = 0;
    cyc(3);
    sb.push_back({2'b10, 8'h1C});
    send_byte(8'hF0, 1'b0);
    send_byte(8'h1C, 1'b0);
    drain("post_rst_drain");
    chk("post_rst_err", err_count, 0);
    chk("post_rst_valid", evt_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
